tnoc_output_port_scheduler: RTL and testbench
=============================================

// Module: tnoc_output_port_scheduler
// PURPOSE
//  Grant scheduler for one router output port: picks one (input port, virtual channel) packet at a time from up to
//  PORTS requesters and holds that grant until the output switch reports the tail flit has left. Sits between the
//  route-computing input blocks and the output switch/VC mux of the output block.
//  Fixed VC priority (VC0 highest) with aging against starvation; round-robin over input ports within each VC.
// PARAMETERS
//  PORTS        5   input ports competing for this output (N,E,S,W,L)
//  CHANNELS     2   virtual channels; CHANNELS >= 1
//  AGING_LIMIT  8   grants given to higher VCs while a lower VC waits before that VC is promoted; AGING_LIMIT >= 1
// PORTS
//  clk             in   1                 clock
//  rst_n           in   1                 synchronous active-low reset
//  i_request       in   PORTS*CHANNELS    bit [v*PORTS+p]: input p holds a head flit on VC v routed to this output
//  i_vc_available  in   CHANNELS          downstream VC v can accept a new packet
//  i_output_free   in   1                 pulse: tail flit of the granted packet accepted by the switch
//  o_grant_valid   out  1                 a packet currently owns the output
//  o_grant_port    out  PORTS             one-hot owning input port (all-zero when !o_grant_valid)
//  o_grant_vc      out  CHANNELS          one-hot owning VC (all-zero when !o_grant_valid)
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge): o_grant_valid=0, o_grant_port=0, o_grant_vc=0, all RR pointers=0, all age
//    counters=0. Reset is honoured mid-packet; the grant is dropped in the same edge, with no tail wait.
//  - States: IDLE (no owner) and BUSY (owner held). All outputs are registered.
//  - Eligibility: request (p,v) is eligible iff i_request[v*PORTS+p] && i_vc_available[v].
//  - Arbitration runs in IDLE, and in BUSY in the cycle i_output_free=1, which gives back-to-back packets with no bubble.
//    With an eligible request at edge N, outputs show the winner after edge N (latency 1 clock).
//  - VC selection: pick the lowest eligible v, except a promoted VC. A VC is promoted when age[v]>=AGING_LIMIT;
//    among promoted VCs, the lowest index wins.
//  - Port selection within the chosen VC: round-robin starting at rr_ptr[v]. After a grant to port p,
//    rr_ptr[v] <= (p+1) mod PORTS. Only the winning VC's pointer moves.
//  - Aging: at each grant, every VC with an eligible-but-losing request does age++ (saturate at AGING_LIMIT).
//    The winning VC and VCs with no eligible request are cleared to 0.
//  - BUSY hold: the owner is kept regardless of i_request or i_vc_available changes until i_output_free.
//    The flit-level flow control belongs to the switch, not this block.
//  - i_output_free:
//      - With no eligible request: IDLE next cycle and outputs cleared.
//      - Otherwise: the new winner is loaded directly. The previous owner may win again only if RR order reaches it.
//      - i_output_free while IDLE is ignored. Simultaneous free and new request is covered by the rules above.
//  - Invariants: o_grant_port and o_grant_vc are one-hot or zero together, both matching o_grant_valid.
//    A grant never names a request that was ineligible at the arbitration edge.
// STRUCTURE
//  - tnoc_pkg: tnoc_sched_state_e {IDLE,BUSY}; onehot-to-index helper function.
//  - Sub-module tnoc_round_robin_arbiter #(REQUESTERS):
//      - ports: clk, rst_n, i_request, i_update, o_grant one-hot; the pointer is held internally.
//      - instantiated once per VC; o_grant is used only for the selected VC, and i_update is driven only for it.
//  - Top: age counters ($clog2(AGING_LIMIT+1) bits per VC), VC selector, state/grant registers.
// TESTING
//  1. Reset: rst_n=0 with all requests high -> o_grant_valid=0, port=0, vc=0; after release, the first grant is
//     port0 VC0 one cycle later.
//  2. RR fairness: VC0 requests from ports 1 and 3 held high, free pulsed every 4 cycles -> grants alternate 1,3,1,3
//     with no idle cycle between packets.
//  3. VC priority and aging:
//      - VC0 port0 and VC1 port2 both requesting continuously, AGING_LIMIT=8.
//      - Expected: eight VC0 grants, then VC1 port2, then VC0 again.
//  4. Credit gating: VC0 request with i_vc_available=2'b10 and VC1 port4 requesting -> VC1 port4 granted.
//     Dropping i_vc_available[1] mid-packet keeps the grant until free.
//  5. Free and idle: single packet, free pulse with all requests low -> o_grant_valid=0 next cycle.
//     Free pulse while IDLE -> no change.
//  6. Mid-packet reset: BUSY on VC1 port3, rst_n=0 for 1 cycle -> outputs zero at that edge.
//     Pointers and ages are reset; the next grant is VC0 port0 if it is requesting.

Source files
------------

// File: rtl/tnoc_pkg.sv
// Shared types and helpers for the output-port grant scheduler.
// Holds the scheduler state encoding and a one-hot decoder used by the arbiters.
package tnoc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } tnoc_sched_state_e;

   function automatic int onehot_to_index(input logic [31:0] vec);
      int idx;
      idx = 0;
      for (int i = 0; i < 32; i++) begin
         if (vec[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/tnoc_output_port_scheduler_if.sv
// Request/grant bundle between the input blocks, the switch and the output scheduler.
// The master side drives requests, credits and the tail-free pulse; the slave side returns the grant.
interface tnoc_output_port_scheduler_if #(
   parameter int PORTS    = 5,
   parameter int CHANNELS = 2
);

   logic [PORTS*CHANNELS-1:0] i_request;
   logic [CHANNELS-1:0]       i_vc_available;
   logic                      i_output_free;
   logic                      o_grant_valid;
   logic [PORTS-1:0]          o_grant_port;
   logic [CHANNELS-1:0]       o_grant_vc;

   modport master (
      output i_request,
      output i_vc_available,
      output i_output_free,
      input  o_grant_valid,
      input  o_grant_port,
      input  o_grant_vc
   );

   modport slave (
      input  i_request,
      input  i_vc_available,
      input  i_output_free,
      output o_grant_valid,
      output o_grant_port,
      output o_grant_vc
   );

endinterface

// File: rtl/tnoc_round_robin_arbiter.sv
// Round-robin arbiter with an internal pointer; the grant is combinational from the pointer,
// and the pointer only advances past the winner when the caller confirms the grant with i_update.
module tnoc_round_robin_arbiter
   import tnoc_pkg::*;
#(
   parameter int REQUESTERS = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REQUESTERS-1:0] i_request,
   input  logic                  i_update,
   output logic [REQUESTERS-1:0] o_grant
);

   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   logic [PW-1:0] r_ptr;
   logic          w_found;
   int            w_idx;
   int            w_winIdx;

   // Scan requesters starting at the pointer, wrapping once around.
   always_comb begin
      o_grant = '0;
      w_found = 1'b0;
      w_idx   = 0;
      for (int i = 0; i < REQUESTERS; i++) begin
         w_idx = int'(r_ptr) + i;
         if (w_idx >= REQUESTERS) begin
            w_idx = w_idx - REQUESTERS;
         end
         if (!w_found && i_request[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            w_found        = 1'b1;
         end
      end
   end

   assign w_winIdx = onehot_to_index(32'(o_grant));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_update && w_found) begin
         r_ptr <= (w_winIdx == REQUESTERS - 1) ? '0 : PW'(w_winIdx + 1);
      end
   end

endmodule

// File: rtl/tnoc_output_port_scheduler.sv
// Output-port grant scheduler: fixed VC priority with aging, round-robin over input ports per VC,
// and a grant that is held until the switch reports the tail flit has left.
module tnoc_output_port_scheduler
   import tnoc_pkg::*;
#(
   parameter int PORTS       = 5,
   parameter int CHANNELS    = 2,
   parameter int AGING_LIMIT = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   tnoc_output_port_scheduler_if.slave   sched_if
);

   localparam int VCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int AW  = $clog2(AGING_LIMIT + 1);

   tnoc_sched_state_e   r_state;
   logic                r_grantValid;
   logic [PORTS-1:0]    r_grantPort;
   logic [CHANNELS-1:0] r_grantVc;
   logic [AW-1:0]       r_age [CHANNELS];

   logic [PORTS-1:0]    w_eligible [CHANNELS];
   logic [PORTS-1:0]    w_rrGrant  [CHANNELS];
   logic [CHANNELS-1:0] w_vcAny;
   logic [CHANNELS-1:0] w_promoted;
   logic [VCW-1:0]      w_selVc;
   logic                w_vcFound;
   logic                w_doGrant;
   logic [CHANNELS-1:0] w_selVcOnehot;

   for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
      assign w_eligible[v] = sched_if.i_request[v*PORTS +: PORTS] & {PORTS{sched_if.i_vc_available[v]}};
      assign w_vcAny[v]    = |w_eligible[v];
      assign w_promoted[v] = (r_age[v] >= AW'(AGING_LIMIT));

      tnoc_round_robin_arbiter #(
         .REQUESTERS (PORTS)
      ) u_rr (
         .clk       (clk),
         .rst_n     (rst_n),
         .i_request (w_eligible[v]),
         .i_update  (w_doGrant && (w_selVc == VCW'(v))),
         .o_grant   (w_rrGrant[v])
      );
   end

   // A promoted VC beats plain priority; otherwise the lowest eligible VC wins.
   always_comb begin
      w_selVc   = '0;
      w_vcFound = 1'b0;
      for (int v = 0; v < CHANNELS; v++) begin
         if (!w_vcFound && w_vcAny[v] && w_promoted[v]) begin
            w_selVc   = VCW'(v);
            w_vcFound = 1'b1;
         end
      end
      for (int v = 0; v < CHANNELS; v++) begin
         if (!w_vcFound && w_vcAny[v]) begin
            w_selVc   = VCW'(v);
            w_vcFound = 1'b1;
         end
      end
   end

   assign w_doGrant     = ((r_state == IDLE) || sched_if.i_output_free) && w_vcFound;
   assign w_selVcOnehot = CHANNELS'(1) << w_selVc;

   // Freeing the output re-arbitrates in the same edge so back-to-back packets leave no bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grantValid <= 1'b0;
         r_grantPort  <= '0;
         r_grantVc    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_doGrant) begin
                  r_state      <= BUSY;
                  r_grantValid <= 1'b1;
                  r_grantPort  <= w_rrGrant[w_selVc];
                  r_grantVc    <= w_selVcOnehot;
               end
            end
            BUSY: begin
               if (sched_if.i_output_free) begin
                  if (w_doGrant) begin
                     r_grantPort <= w_rrGrant[w_selVc];
                     r_grantVc   <= w_selVcOnehot;
                  end else begin
                     r_state      <= IDLE;
                     r_grantValid <= 1'b0;
                     r_grantPort  <= '0;
                     r_grantVc    <= '0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // Losers that were eligible at a grant age up; the winner and absent VCs start over.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int v = 0; v < CHANNELS; v++) begin
            r_age[v] <= '0;
         end
      end else if (w_doGrant) begin
         for (int v = 0; v < CHANNELS; v++) begin
            if (w_selVc == VCW'(v)) begin
               r_age[v] <= '0;
            end else if (w_vcAny[v]) begin
               if (r_age[v] < AW'(AGING_LIMIT)) begin
                  r_age[v] <= r_age[v] + AW'(1);
               end
            end else begin
               r_age[v] <= '0;
            end
         end
      end
   end

   assign sched_if.o_grant_valid = r_grantValid;
   assign sched_if.o_grant_port  = r_grantPort;
   assign sched_if.o_grant_vc    = r_grantVc;

endmodule

// File: tb/tb_tnoc_output_port_scheduler.sv
// Scoreboard bench for the output-port scheduler: stimulus feeds a reference model that queues the
// expected grant per clock, and an independent monitor compares the DUT outputs after every edge.
module tb_tnoc_output_port_scheduler;

   localparam int PORTS       = 5;
   localparam int CHANNELS    = 2;
   localparam int AGING_LIMIT = 8;
   localparam int NREQ        = PORTS * CHANNELS;

   typedef struct {
      logic                valid;
      logic [PORTS-1:0]    port;
      logic [CHANNELS-1:0] vc;
   } exp_t;

   logic clk;
   logic rst_n;

   exp_t expQ[$];
   int   vectors;
   int   miscompares;

   int   mPtr [CHANNELS];
   int   mAge [CHANNELS];
   bit   mBusy;
   int   mPort;
   int   mVc;

   tnoc_output_port_scheduler_if #(.PORTS(PORTS), .CHANNELS(CHANNELS)) schedIf ();

   tnoc_output_port_scheduler #(
      .PORTS       (PORTS),
      .CHANNELS    (CHANNELS),
      .AGING_LIMIT (AGING_LIMIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sched_if (schedIf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one call per clock edge, working from the arbitration rules directly.
   task automatic modelStep(input bit rstn, input logic [NREQ-1:0] req,
                            input logic [CHANNELS-1:0] avail, input bit free);
      bit elig [CHANNELS][PORTS];
      bit anyV [CHANNELS];
      int win;
      int chosen;
      int p;
      if (!rstn) begin
         for (int v = 0; v < CHANNELS; v++) begin
            mPtr[v] = 0;
            mAge[v] = 0;
         end
         mBusy = 0;
         return;
      end
      if (mBusy && !free) return;
      for (int v = 0; v < CHANNELS; v++) begin
         anyV[v] = 0;
         for (int q = 0; q < PORTS; q++) begin
            elig[v][q] = req[v*PORTS+q] && avail[v];
            if (elig[v][q]) anyV[v] = 1;
         end
      end
      win = -1;
      for (int v = 0; v < CHANNELS; v++)
         if (win < 0 && anyV[v] && mAge[v] >= AGING_LIMIT) win = v;
      for (int v = 0; v < CHANNELS; v++)
         if (win < 0 && anyV[v]) win = v;
      if (win < 0) begin
         mBusy = 0;
         return;
      end
      chosen = -1;
      for (int k = 0; k < PORTS; k++) begin
         p = (mPtr[win] + k) % PORTS;
         if (chosen < 0 && elig[win][p]) chosen = p;
      end
      for (int v = 0; v < CHANNELS; v++) begin
         if (v == win)      mAge[v] = 0;
         else if (anyV[v])  mAge[v] = (mAge[v] + 1 > AGING_LIMIT) ? AGING_LIMIT : mAge[v] + 1;
         else               mAge[v] = 0;
      end
      mPtr[win] = (chosen + 1) % PORTS;
      mBusy     = 1;
      mPort     = chosen;
      mVc       = win;
   endtask

   // Drives one clock of inputs on the falling edge and queues the grant expected after the next rising edge.
   task automatic applyStimulus(input bit rstn, input logic [NREQ-1:0] req,
                                input logic [CHANNELS-1:0] avail, input bit free);
      exp_t e;
      @(negedge clk);
      rst_n                  = rstn;
      schedIf.i_request      = req;
      schedIf.i_vc_available = avail;
      schedIf.i_output_free  = free;
      modelStep(rstn, req, avail, free);
      e.valid = mBusy;
      e.port  = mBusy ? PORTS'(1) << mPort : '0;
      e.vc    = mBusy ? CHANNELS'(1) << mVc : '0;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      if (schedIf.o_grant_valid !== e.valid || schedIf.o_grant_port !== e.port ||
          schedIf.o_grant_vc !== e.vc) begin
         miscompares++;
         $display("[TB] FAIL grant vec%0d: got valid=%0b port=%b vc=%b, expected valid=%0b port=%b vc=%b",
                  vectors, schedIf.o_grant_valid, schedIf.o_grant_port, schedIf.o_grant_vc,
                  e.valid, e.port, e.vc);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      int waitCycles;
      vectors                = 0;
      miscompares            = 0;
      rst_n                  = 1'b0;
      schedIf.i_request      = '0;
      schedIf.i_vc_available = '0;
      schedIf.i_output_free  = 1'b0;

      $display("[TB] reset with all requests high");
      applyStimulus(0, '1, 2'b11, 0);
      applyStimulus(0, '1, 2'b11, 1);
      applyStimulus(1, '1, 2'b11, 0);
      applyStimulus(1, '1, 2'b11, 0);

      $display("[TB] round robin on VC0 ports 1 and 3");
      applyStimulus(0, '0, 2'b11, 0);
      for (int i = 0; i < 16; i++) applyStimulus(1, 10'b00000_01010, 2'b11, (i % 4) == 3);

      $display("[TB] VC priority and aging");
      applyStimulus(0, '0, 2'b11, 0);
      for (int i = 0; i < 24; i++) applyStimulus(1, 10'b00100_00001, 2'b11, (i % 2) == 1);

      $display("[TB] credit gating");
      applyStimulus(0, '0, 2'b11, 0);
      applyStimulus(1, 10'b10000_00001, 2'b10, 0);
      applyStimulus(1, 10'b10000_00001, 2'b00, 0);
      applyStimulus(1, 10'b00000_00000, 2'b01, 0);
      applyStimulus(1, 10'b10000_00001, 2'b01, 1);
      applyStimulus(1, 10'b10000_00001, 2'b11, 0);

      $display("[TB] free and idle");
      applyStimulus(0, '0, 2'b11, 0);
      applyStimulus(1, 10'b00000_00100, 2'b11, 0);
      applyStimulus(1, '0, 2'b11, 0);
      applyStimulus(1, '0, 2'b11, 1);
      applyStimulus(1, '0, 2'b11, 0);
      applyStimulus(1, '0, 2'b11, 1);
      applyStimulus(1, '0, 2'b11, 0);

      $display("[TB] mid-packet reset");
      applyStimulus(0, '0, 2'b11, 0);
      applyStimulus(1, 10'b00000_00001, 2'b11, 0);
      applyStimulus(1, 10'b01000_00000, 2'b11, 1);
      applyStimulus(1, 10'b01000_00001, 2'b11, 0);
      applyStimulus(0, 10'b01000_00001, 2'b11, 0);
      applyStimulus(1, 10'b01000_00001, 2'b11, 0);
      applyStimulus(1, 10'b01000_00001, 2'b11, 0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(0, 63) != 0), NREQ'($urandom()), CHANNELS'($urandom()),
                       ($urandom_range(0, 2) == 0));
      end
      applyStimulus(1, '0, 2'b11, 1);
      applyStimulus(1, '0, 2'b11, 0);

      waitCycles = 0;
      while (expQ.size() > 0 && waitCycles < 20) begin
         @(posedge clk);
         waitCycles++;
      end
      #2;
      if (expQ.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
